// File: rtl/op_latency_monitor.sv
// Per-channel ALU/memory latency monitor: checks done arrives exactly
// LAT_TABLE[op] cycles after start, reports violations, counts pass/err.
// Ports: clk, reset_n (sync, active-low), enable, clr_cnt,
//   start/op/done per channel in; viol_valid/viol_code/viol_op/viol_lat,
//   pass_cnt/err_cnt per channel out (channel c at slice c).
module op_latency_monitor #(
  parameter int NUM_CH  = 2,
  parameter int OP_W    = 4,
  parameter int CNT_W   = 5,
  parameter logic [(1<<OP_W)*CNT_W-1:0] LAT_TABLE = {
    5'd0, 5'd0, 5'd10, 5'd10, 5'd3, 5'd3, 5'd4, 5'd3,
    5'd1, 5'd1, 5'd1, 5'd1, 5'd1, 5'd1, 5'd1, 5'd0},
  parameter int TIMEOUT = 31,
  parameter int ERR_W   = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic                    clr_cnt,
  input  logic [NUM_CH-1:0]       start,
  input  logic [NUM_CH*OP_W-1:0]  op,
  input  logic [NUM_CH-1:0]       done,
  output logic [NUM_CH-1:0]       viol_valid,
  output logic [NUM_CH*3-1:0]     viol_code,
  output logic [NUM_CH*OP_W-1:0]  viol_op,
  output logic [NUM_CH*CNT_W-1:0] viol_lat,
  output logic [NUM_CH*ERR_W-1:0] pass_cnt,
  output logic [NUM_CH*ERR_W-1:0] err_cnt
);

  typedef enum logic [1:0] {IDLE, BUSY, LATE} state_t;

  localparam logic [CNT_W-1:0] TO  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  for (genvar i = 0; i < (1 << OP_W); i++) begin : g_chk
    if (int'(LAT_TABLE[i*CNT_W +: CNT_W]) > TIMEOUT) begin : g_bad
      $error("LAT_TABLE entry exceeds TIMEOUT");
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    state_t           r_st;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_lat;
    logic [OP_W-1:0]  r_op;
    logic             r_vv;
    logic [2:0]       r_vcode;
    logic [OP_W-1:0]  r_vop;
    logic [CNT_W-1:0] r_vlat;
    logic [ERR_W-1:0] r_pass;
    logic [ERR_W-1:0] r_err;

    logic [OP_W-1:0]  w_op_in;
    logic [CNT_W-1:0] w_new_lat;
    logic [CNT_W-1:0] w_inc;
    logic             w_ontime;
    logic             w_pass;
    logic [2:0]       w_code;
    logic [OP_W-1:0]  w_eop;
    logic [CNT_W-1:0] w_elat;
    state_t           w_nst;
    logic [CNT_W-1:0] w_ncnt;
    logic [CNT_W-1:0] w_nlat;
    logic [OP_W-1:0]  w_nop;

    assign w_op_in   = op[c*OP_W +: OP_W];
    assign w_new_lat = LAT_TABLE[int'(w_op_in)*CNT_W +: CNT_W];
    assign w_inc     = (r_cnt == TO) ? r_cnt : r_cnt + ONE;
    assign w_ontime  = done[c] && (r_cnt == r_lat);

    always_comb begin
      w_pass = 1'b0;
      w_code = 3'd0;
      w_eop  = r_op;
      w_elat = r_cnt;
      w_nst  = r_st;
      w_ncnt = r_cnt;
      w_nlat = r_lat;
      w_nop  = r_op;
      unique case (r_st)
        IDLE: begin
          if (start[c]) begin
            if (w_new_lat != '0) begin
              w_nst  = BUSY;
              w_nop  = w_op_in;
              w_nlat = w_new_lat;
              w_ncnt = ONE;
            end
          end else if (done[c]) begin
            w_code = 3'd5;
            w_eop  = '0;
            w_elat = '0;
          end
        end
        BUSY, LATE: begin
          if (start[c]) begin
            // restart: either clean back-to-back or overlap on old op
            if (r_st == BUSY && w_ontime) w_pass = 1'b1;
            else                          w_code = 3'd4;
            if (w_new_lat != '0) begin
              w_nst  = BUSY;
              w_nop  = w_op_in;
              w_nlat = w_new_lat;
              w_ncnt = ONE;
            end else begin
              w_nst  = IDLE;
              w_ncnt = '0;
            end
          end else if (r_st == BUSY) begin
            if (done[c]) begin
              if (r_cnt == r_lat) w_pass = 1'b1;
              else                w_code = 3'd1;
              w_nst  = IDLE;
              w_ncnt = '0;
            end else if (r_cnt == r_lat) begin
              w_code = 3'd2;
              w_elat = r_lat;
              w_nst  = LATE;
              w_ncnt = w_inc;
            end else begin
              w_ncnt = w_inc;
            end
          end else begin
            // late already reported; a later done closes silently
            if (done[c]) begin
              w_nst  = IDLE;
              w_ncnt = '0;
            end else if (r_cnt == TO) begin
              w_code = 3'd3;
              w_nst  = IDLE;
              w_ncnt = '0;
            end else begin
              w_ncnt = w_inc;
            end
          end
        end
        default: begin
          w_nst  = IDLE;
          w_ncnt = '0;
        end
      endcase
    end

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        r_st    <= IDLE;
        r_cnt   <= '0;
        r_lat   <= '0;
        r_op    <= '0;
        r_vv    <= 1'b0;
        r_vcode <= '0;
        r_vop   <= '0;
        r_vlat  <= '0;
        r_pass  <= '0;
        r_err   <= '0;
      end else begin
        r_vv    <= 1'b0;
        r_vcode <= '0;
        r_vop   <= '0;
        r_vlat  <= '0;
        if (!enable) begin
          r_st  <= IDLE;
          r_cnt <= '0;
        end else begin
          r_st  <= w_nst;
          r_cnt <= w_ncnt;
          r_lat <= w_nlat;
          r_op  <= w_nop;
          if (w_code != 3'd0) begin
            r_vv    <= 1'b1;
            r_vcode <= w_code;
            r_vop   <= w_eop;
            r_vlat  <= w_elat;
          end
        end
        if (clr_cnt) begin
          r_pass <= '0;
          r_err  <= '0;
        end else if (enable) begin
          if (w_pass && !(&r_pass))          r_pass <= r_pass + 1'b1;
          if (w_code != 3'd0 && !(&r_err))   r_err  <= r_err + 1'b1;
        end
      end
    end

    assign viol_valid[c]               = r_vv;
    assign viol_code[c*3 +: 3]         = r_vcode;
    assign viol_op[c*OP_W +: OP_W]     = r_vop;
    assign viol_lat[c*CNT_W +: CNT_W]  = r_vlat;
    assign pass_cnt[c*ERR_W +: ERR_W]  = r_pass;
    assign err_cnt[c*ERR_W +: ERR_W]   = r_err;
  end

endmodule

// File: tb/tb_op_latency_monitor.sv
// Directed self-checking bench for op_latency_monitor.
// Inputs driven after negedge, outputs sampled at negedge.
module tb_op_latency_monitor;

  localparam int NC = 2;
  localparam int OW = 4;
  localparam int CW = 5;
  localparam int EW = 16;
  localparam logic [16*5-1:0] LAT = {
    5'd0, 5'd0, 5'd10, 5'd10, 5'd3, 5'd3, 5'd4, 5'd3,
    5'd1, 5'd1, 5'd1, 5'd1, 5'd1, 5'd1, 5'd1, 5'd0};

  localparam logic [3:0] ADD  = 4'd1;
  localparam logic [3:0] XOR  = 4'd5;
  localparam logic [3:0] MUL  = 4'd8;
  localparam logic [3:0] SP0  = 4'd9;
  localparam logic [3:0] LOAD = 4'd13;

  logic clk = 1'b0;
  logic reset_n;
  logic enable;
  logic clr_cnt;
  logic [NC-1:0]    start;
  logic [NC*OW-1:0] op;
  logic [NC-1:0]    done;
  logic [NC-1:0]    viol_valid;
  logic [NC*3-1:0]  viol_code;
  logic [NC*OW-1:0] viol_op;
  logic [NC*CW-1:0] viol_lat;
  logic [NC*EW-1:0] pass_cnt;
  logic [NC*EW-1:0] err_cnt;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  op_latency_monitor #(
    .NUM_CH(NC), .OP_W(OW), .CNT_W(CW), .LAT_TABLE(LAT),
    .TIMEOUT(31), .ERR_W(EW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .clr_cnt(clr_cnt), .start(start), .op(op), .done(done),
    .viol_valid(viol_valid), .viol_code(viol_code),
    .viol_op(viol_op), .viol_lat(viol_lat),
    .pass_cnt(pass_cnt), .err_cnt(err_cnt)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clr();
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
  endtask

  function automatic logic [2:0] vc(input int c);
    return viol_code[c*3 +: 3];
  endfunction
  function automatic logic [3:0] vo(input int c);
    return viol_op[c*OW +: OW];
  endfunction
  function automatic logic [4:0] vl(input int c);
    return viol_lat[c*CW +: CW];
  endfunction
  function automatic logic [15:0] pc(input int c);
    return pass_cnt[c*EW +: EW];
  endfunction
  function automatic logic [15:0] ec(input int c);
    return err_cnt[c*EW +: EW];
  endfunction

  initial begin
    int nv;
    reset_n = 1'b0;
    enable  = 1'b1;
    clr_cnt = 1'b0;
    start   = '0;
    op      = '0;
    done    = '0;
    tick();
    tick();
    check("rst_vv", 32'(viol_valid), 0);
    check("rst_pass", pass_cnt, 0);
    check("rst_err", err_cnt, 0);
    reset_n = 1'b1;
    tick();

    // 1: add on time
    start[0] = 1'b1; op[3:0] = ADD;
    tick();
    start[0] = 1'b0; done[0] = 1'b1;
    tick();
    done[0] = 1'b0;
    check("t1_vv", 32'(viol_valid), 0);
    check("t1_pass", 32'(pc(0)), 1);

    // 2: load done early after 7
    clr();
    start[0] = 1'b1; op[3:0] = LOAD;
    tick();
    start[0] = 1'b0;
    repeat (6) tick();
    check("t2_quiet", 32'(viol_valid), 0);
    done[0] = 1'b1;
    tick();
    done[0] = 1'b0;
    check("t2_vv", 32'(viol_valid), 32'h1);
    check("t2_code", 32'(vc(0)), 1);
    check("t2_lat", 32'(vl(0)), 7);
    check("t2_op", 32'(vo(0)), 32'(LOAD));
    tick();
    check("t2_err", 32'(ec(0)), 1);
    check("t2_vv_off", 32'(viol_valid), 0);

    // 3: ch1 mul never done -> late then hang
    clr();
    start[1] = 1'b1; op[7:4] = MUL;
    tick();
    start[1] = 1'b0;
    tick();
    tick();
    check("t3_quiet", 32'(viol_valid), 0);
    tick();
    check("t3_late_vv", 32'(viol_valid), 32'h2);
    check("t3_late_code", 32'(vc(1)), 2);
    check("t3_late_lat", 32'(vl(1)), 3);
    check("t3_late_op", 32'(vo(1)), 32'(MUL));
    nv = 0;
    for (int i = 0; i < 27; i++) begin
      tick();
      if (viol_valid != '0) nv++;
    end
    check("t3_gap", 32'(nv), 0);
    tick();
    check("t3_hang_vv", 32'(viol_valid), 32'h2);
    check("t3_hang_code", 32'(vc(1)), 3);
    check("t3_hang_lat", 32'(vl(1)), 31);
    check("t3_err", 32'(ec(1)), 2);
    check("t3_err0", 32'(ec(0)), 0);

    // 4: sp0 on time with back-to-back xor
    clr();
    start[0] = 1'b1; op[3:0] = SP0;
    tick();
    start[0] = 1'b0;
    repeat (3) tick();
    start[0] = 1'b1; op[3:0] = XOR; done[0] = 1'b1;
    tick();
    check("t4_vv_a", 32'(viol_valid), 0);
    start[0] = 1'b0;
    tick();
    done[0] = 1'b0;
    check("t4_vv_b", 32'(viol_valid), 0);
    check("t4_pass", 32'(pc(0)), 2);
    check("t4_err", 32'(ec(0)), 0);

    // 5: mul restarted at cnt=2
    clr();
    start[0] = 1'b1; op[3:0] = MUL;
    tick();
    start[0] = 1'b0;
    tick();
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    check("t5_code", 32'(vc(0)), 4);
    check("t5_lat", 32'(vl(0)), 2);
    check("t5_op", 32'(vo(0)), 32'(MUL));
    tick();
    tick();
    done[0] = 1'b1;
    tick();
    done[0] = 1'b0;
    check("t5_vv", 32'(viol_valid), 0);
    check("t5_pass", 32'(pc(0)), 1);
    check("t5_err", 32'(ec(0)), 1);

    // 6: error counter saturation and clear priority
    force dut.g_ch[0].r_err = 16'hFFFF;
    tick();
    release dut.g_ch[0].r_err;
    check("t6_forced", 32'(ec(0)), 32'hFFFF);
    done[0] = 1'b1;
    tick();
    check("t6_spur", 32'(vc(0)), 5);
    check("t6_sat", 32'(ec(0)), 32'hFFFF);
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    done[0] = 1'b0;
    check("t6_clr_vv", 32'(viol_valid), 32'h1);
    check("t6_clr", 32'(ec(0)), 0);

    // 7: reset mid-busy, then spurious done
    start[0] = 1'b1; op[3:0] = LOAD;
    tick();
    start[0] = 1'b0;
    tick();
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("t7_vv", 32'(viol_valid), 0);
    check("t7_code", 32'(viol_code), 0);
    check("t7_pass", 32'(pass_cnt), 0);
    check("t7_err", 32'(err_cnt), 0);
    done[0] = 1'b1;
    tick();
    done[0] = 1'b0;
    check("t7_spur_code", 32'(vc(0)), 5);
    check("t7_spur_lat", 32'(vl(0)), 0);
    check("t7_err1", 32'(ec(0)), 1);

    // enable drop abandons op silently; later done is spurious
    start[1] = 1'b1; op[7:4] = MUL;
    tick();
    start[1] = 1'b0;
    enable = 1'b0;
    tick();
    check("en_vv", 32'(viol_valid), 0);
    enable = 1'b1;
    done[1] = 1'b1;
    tick();
    done[1] = 1'b0;
    check("en_spur", 32'(vc(1)), 5);
    check("en_err", 32'(ec(1)), 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
